// File: rtl/pattern_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_serializer                                                   |
// | Paced MSB-first serializer with start/abort handshake and done pulse.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pattern_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 25000000,
   parameter int LEN_W = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [WIDTH-1:0] PATTERN,
   input  logic [LEN_W-1:0] LEN,
   input  logic             ABORT,
   output logic             SER_OUT,
   output logic             BIT_STROBE,
   output logic             BUSY,
   output logic             DONE
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] C_DIV_RELOAD = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] C_DIV_ONE    = DIV_W'(1);
   localparam logic [LEN_W-1:0] C_LEN_MAX    = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] C_LEN_ONE    = LEN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   shreg_q,  shreg_d;
   logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;
   logic [DIV_W-1:0]   divcnt_q, divcnt_d;
   logic               strobe_q, strobe_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic               w_start_ok;

   // The shift register is cleared on every exit from SHIFT, so its MSB
   // doubles as the registered serial output and idles at 0.
   assign SER_OUT    = shreg_q[WIDTH-1];
   assign BIT_STROBE = strobe_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;

   assign w_start_ok = START && !ABORT && (LEN != '0) && (LEN <= C_LEN_MAX);

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      divcnt_d = divcnt_q;
      strobe_d = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (w_start_ok) begin
               state_d  = S_SHIFT;
               shreg_d  = PATTERN;
               bitcnt_d = LEN;
               divcnt_d = C_DIV_RELOAD;
               strobe_d = 1'b1;
               busy_d   = 1'b1;
            end
         end
         S_SHIFT: begin
            if (ABORT) begin
               state_d  = S_IDLE;
               shreg_d  = '0;
               bitcnt_d = '0;
               divcnt_d = '0;
               busy_d   = 1'b0;
            end else if (divcnt_q == '0) begin
               if (bitcnt_q > C_LEN_ONE) begin
                  shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - C_LEN_ONE;
                  divcnt_d = C_DIV_RELOAD;
                  strobe_d = 1'b1;
               end else begin
                  state_d  = S_DONE;
                  shreg_d  = '0;
                  bitcnt_d = '0;
                  divcnt_d = '0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end
            end else begin
               divcnt_d = divcnt_q - C_DIV_ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
            divcnt_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         divcnt_q <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         divcnt_q <= divcnt_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

endmodule
`default_nettype wire
